serial_add_ctrl: RTL and testbench

- Bit-serial add/subtract engine. Drives one instance of the team's existing 1-bit full-adder cell `add` with one operand bit pair per clock, LSB first.
- Holds the carry in a flop between cycles and assembles the WIDTH-bit sum in a shift register.
- Sits directly upstream of the `add` cell and consumes its result/cout each cycle. Gives the ALU an area-minimal add path with a start/done handshake.

---
 rtl/serial_add_ctrl.sv | 151 +++++++++++++++
 tb/tb_serial_add_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract engine driving a 1-bit full-adder cell, LSB first.
// Define SERIAL_ADD_FLAGS_EN to build the registered overflow/zero flags.

module add (
    input  logic src1,
    input  logic src2,
    input  logic cin,
    output logic result,
    output logic cout
);
    assign result = src1 ^ src2 ^ cin;
    assign cout   = (src1 & src2) | (cin & (src1 ^ src2));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-2:0] acc;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    count;
    logic             carry;
    logic             cout_q;
    logic             cell_result;
    logic             cell_cout;
    logic             last;

    add u_add (
        .src1   (op_a[0]),
        .src2   (op_b[0]),
        .cin    (carry),
        .result (cell_result),
        .cout   (cell_cout)
    );

    // Working shift register plus the bit just produced; on the last edge this is the full sum.
    assign shifted = {cell_result, acc};
    assign last    = (state == RUN) && (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            count    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= src1;
                        op_b  <= sub ? ~src2 : src2;
                        carry <= sub ? 1'b1 : cin;
                        count <= '0;
                    end
                end
                RUN: begin
                    acc   <= shifted[WIDTH-1:1];
                    carry <= cell_cout;
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    count <= count + 1'b1;
                    if (last) begin
                        result_q <= shifted;
                        cout_q   <= cell_cout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADD_FLAGS_EN
    logic any_one;
    logic ovf_q;
    logic zero_q;

    // On the last RUN edge op_a[0]/op_b[0] hold the operand MSBs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_one <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                any_one <= 1'b0;
            end else if (state == RUN) begin
                any_one <= any_one | cell_result;
                if (last) begin
                    ovf_q  <= (op_a[0] == op_b[0]) && (cell_result != op_a[0]);
                    zero_q <= ~(any_one | cell_result);
                end
            end
        end
    end

    assign overflow = ovf_q;
    assign zero     = zero_q;
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign result = result_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized and directed bench for serial_add_ctrl (WIDTH=8) against an integer reference model.
module tb_serial_add_ctrl;
    localparam int W = 8;
`ifdef SERIAL_ADD_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] src1 = '0;
    logic [W-1:0] src2 = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
    logic         zero;

    int n_vec  = 0;
    int n_miss = 0;

    logic [W-1:0] held_result = '0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .src1     (src1),
        .src2     (src2),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the (possibly inverted) operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic c, output logic [W-1:0] r, output logic co,
                         output logic ov, output logic z);
        logic [W-1:0] bp;
        int           cc;
        int           uns;
        int           sgn;
        bp  = s ? ~b : b;
        cc  = s ? 1 : int'(c);
        uns = int'(a) + int'(bp) + cc;
        sgn = int'($signed(a)) + int'($signed(bp)) + cc;
        r   = W'(uns);
        co  = (uns >= (1 << W));
        ov  = FLAGS && ((sgn > (1 << (W - 1)) - 1) || (sgn < -(1 << (W - 1))));
        z   = FLAGS && (r == '0);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic c, input bit inject);
        logic [W-1:0] er;
        logic         eco;
        logic         eov;
        logic         ez;
        int           lat;
        int           dones;
        int           busys;
        model(a, b, s, c, er, eco, eov, ez);
        @(negedge clk);
        src1  = a;
        src2  = b;
        sub   = s;
        cin   = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        src1  = W'($urandom);
        src2  = W'($urandom);
        sub   = 1'($urandom);
        cin   = 1'($urandom);
        lat   = -1;
        dones = 0;
        busys = 0;
        for (int n = 0; n < W + 4; n++) begin
            if (busy) busys++;
            if (done) begin
                dones++;
                if (lat < 0) lat = n;
            end
            if (n == W / 2) check({tag, "_hidden"}, 64'(result), 64'(held_result));
            if (inject && n == 2) begin
                start = 1'b1;
                src1  = ~a;
                src2  = W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        check({tag, "_latency"}, 64'(lat), 64'(W));
        check({tag, "_dones"}, 64'(dones), 64'd1);
        check({tag, "_busy_cycles"}, 64'(busys), 64'(W + 1));
        check({tag, "_result"}, 64'(result), 64'(er));
        check({tag, "_cout"}, 64'(cout), 64'(eco));
        check({tag, "_overflow"}, 64'(overflow), 64'(eov));
        check({tag, "_zero"}, 64'(zero), 64'(ez));
        held_result = er;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_result"}, 64'(result), 64'd0);
        check({tag, "_cout"}, 64'(cout), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
        check({tag, "_zero"}, 64'(zero), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_done;
        #3;
        check_cleared("reset");
        @(negedge clk);
        rst = 1'b0;

        run_op("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op("add_cin", 8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
        run_op("sub_borrow", 8'h05, 8'h07, 1'b1, 1'b1, 1'b0);
        run_op("sub_pos", 8'h07, 8'h05, 1'b1, 1'b0, 1'b0);
        run_op("sub_ovf", 8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
        run_op("handshake", 8'h3C, 8'h41, 1'b0, 1'b0, 1'b1);

        // Abort during the fourth RUN cycle.
        @(negedge clk);
        src1  = 8'h55;
        src2  = 8'h22;
        sub   = 1'b0;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_cleared("abort");
        seen_done = 0;
        repeat (W + 2) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_cleared("post_abort");
        held_result = '0;
        run_op("after_abort", 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
